// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter slice: FSM encoding,
// requester indices and the default burst limit.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam int unsigned DEFAULT_MAX_BURST = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to rr_ptr.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic rr_ptr,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) begin
      winner = rr_ptr;
    end else if (req1) begin
      winner = PORT_DBG;
    end else begin
      winner = PORT_CPU;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the CPU (port 0) and the debug DMA
// (port 1) with round-robin ownership and bounded bursts.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_MemWrite,
  output logic              mem_MemRead,
  output logic [DATA_W-1:0] mem_WriteData,
  input  logic [DATA_W-1:0] mem_ReadData,
  output logic              busy
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(MAX_BURST - 1);

  state_e            state_q;
  logic              rr_ptr_q;
  logic [CNT_W-1:0]  beat_cnt_q;
  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  logic arb_valid, arb_winner;
  logic any_gnt, sel_we;
  logic own_req, oth_req, other;
  logic release_own;

  rr_arb2 u_rr_arb2 (
    .req0   (req0),
    .req1   (req1),
    .rr_ptr (rr_ptr_q),
    .valid  (arb_valid),
    .winner (arb_winner)
  );

  // Grants are gated by reset so a burst is cut off the moment reset drops.
  always_comb begin
    gnt0          = reset & (state_q == OWN0) & req0;
    gnt1          = reset & (state_q == OWN1) & req1;
    any_gnt       = gnt0 | gnt1;
    sel_we        = gnt0 ? we0 : we1;
    mem_address   = gnt0 ? addr0 : (gnt1 ? addr1 : '0);
    mem_MemWrite  = any_gnt & sel_we;
    mem_MemRead   = any_gnt & ~sel_we;
    mem_WriteData = mem_MemWrite ? (gnt0 ? wdata0 : wdata1) : '0;
  end

  always_comb begin
    own_req = 1'b0;
    oth_req = 1'b0;
    other   = PORT_CPU;
    case (state_q)
      OWN0: begin
        own_req = req0;
        oth_req = req1;
        other   = PORT_DBG;
      end
      OWN1: begin
        own_req = req1;
        oth_req = req0;
        other   = PORT_CPU;
      end
      default: ;
    endcase
    release_own = ~own_req | (any_gnt & oth_req & (beat_cnt_q == BEAT_LAST));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= PORT_CPU;
      beat_cnt_q <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      rvalid0_q <= gnt0 & ~we0;
      rvalid1_q <= gnt1 & ~we1;
      if (gnt0 && !we0) rdata0_q <= mem_ReadData;
      if (gnt1 && !we1) rdata1_q <= mem_ReadData;
      case (state_q)
        IDLE: begin
          if (arb_valid) state_q <= (arb_winner == PORT_DBG) ? OWN1 : OWN0;
        end
        OWN0, OWN1: begin
          if (release_own) begin
            rr_ptr_q   <= other;
            beat_cnt_q <= '0;
            if (oth_req) state_q <= (other == PORT_DBG) ? OWN1 : OWN0;
            else         state_q <= IDLE;
          end else if (any_gnt && beat_cnt_q != BEAT_LAST) begin
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized bench for dmem_arbiter against a cycle-level reference
// model of ownership, turn order and a shadow copy of memory.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          rq [2];
  logic          wq [2];
  logic [AW-1:0] aq [2];
  logic [DW-1:0] dq [2];

  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_address;
  logic          mem_MemWrite, mem_MemRead, busy;
  logic [DW-1:0] mem_WriteData, mem_ReadData;

  logic [DW-1:0] tb_mem  [64];
  logic [DW-1:0] ref_mem [64];

  int            vectors = 0;
  int            miscompares = 0;

  // reference model: owner -1 means nobody holds the memory
  int            owner, turn, burst;
  logic          exp_rv [2];
  logic [DW-1:0] exp_rd [2];
  logic          last_gnt [2];
  logic          last_dgnt [2];

  assign req0 = rq[0];  assign req1 = rq[1];
  assign we0  = wq[0];  assign we1  = wq[1];
  assign addr0 = aq[0]; assign addr1 = aq[1];
  assign wdata0 = dq[0]; assign wdata1 = dq[1];
  assign mem_ReadData = tb_mem[mem_address[7:2]];

  always #5 clock = ~clock;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_address(mem_address), .mem_MemWrite(mem_MemWrite),
    .mem_MemRead(mem_MemRead), .mem_WriteData(mem_WriteData),
    .mem_ReadData(mem_ReadData), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic set_port(input int p, input logic r, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    rq[p] = r; wq[p] = w; aq[p] = a; dq[p] = d;
  endtask

  // One clock: check outputs at the falling edge, then advance the model.
  task automatic cycle();
    logic          g [2];
    logic          rst, mw, exw, exr;
    logic [AW-1:0] ma, ea;
    logic [DW-1:0] md, ed;
    int            o;
    @(negedge clock);
    rst = reset;
    ea = '0; ed = '0; exw = 1'b0; exr = 1'b0;
    for (int p = 0; p < 2; p++) begin
      g[p] = rst && (owner == p) && rq[p];
      if (g[p]) begin
        ea = aq[p];
        if (wq[p]) begin ed = dq[p]; exw = 1'b1; end
        else exr = 1'b1;
      end
    end
    check("gnt0", gnt0, g[0]);
    check("gnt1", gnt1, g[1]);
    check("mem_MemWrite", mem_MemWrite, exw);
    check("mem_MemRead", mem_MemRead, exr);
    check("mem_address", mem_address, ea);
    check("mem_WriteData", mem_WriteData, ed);
    check("rw_exclusive", mem_MemWrite & mem_MemRead, 0);
    check("rvalid0", rvalid0, exp_rv[0]);
    check("rvalid1", rvalid1, exp_rv[1]);
    check("rdata0", rdata0, exp_rd[0]);
    check("rdata1", rdata1, exp_rd[1]);
    check("busy", busy, owner >= 0);
    mw = mem_MemWrite; ma = mem_address; md = mem_WriteData;
    last_gnt = g;
    last_dgnt[0] = gnt0; last_dgnt[1] = gnt1;
    @(posedge clock);
    #1;
    if (mw) tb_mem[ma[7:2]] = md;
    if (!rst) begin
      owner = -1; turn = 0; burst = 0;
      exp_rv = '{1'b0, 1'b0};
      exp_rd = '{'0, '0};
    end else begin
      for (int p = 0; p < 2; p++) begin
        exp_rv[p] = g[p] && !wq[p];
        if (g[p] && !wq[p]) exp_rd[p] = ref_mem[aq[p][7:2]];
        if (g[p] && wq[p]) ref_mem[aq[p][7:2]] = dq[p];
      end
      if (owner < 0) begin
        if (rq[0] && rq[1]) owner = turn;
        else if (rq[0]) owner = 0;
        else if (rq[1]) owner = 1;
      end else begin
        o = 1 - owner;
        if (!rq[owner] || (g[owner] && rq[o] && burst == MB - 1)) begin
          turn = o; burst = 0;
          owner = rq[o] ? o : -1;
        end else if (g[owner] && burst < MB - 1) begin
          burst++;
        end
      end
    end
  endtask

  // Holds a transaction on port p until the DUT or the model grants it.
  task automatic issue(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    set_port(p, 1'b1, w, a, d);
    do begin
      cycle();
      n++;
    end while (!last_dgnt[p] && !last_gnt[p] && n < 20);
    check("issue_gnt", last_dgnt[p], 1);
  endtask

  task automatic random_phase(input int ncyc, input int pct0, input int pct1);
    int pct;
    for (int i = 0; i < ncyc; i++) begin
      for (int p = 0; p < 2; p++) begin
        pct = (p == 0) ? pct0 : pct1;
        if (!rq[p] || last_gnt[p])
          set_port(p, $urandom_range(0, 99) < pct, $urandom_range(0, 1) == 1,
                   AW'($urandom_range(0, 255)), DW'($urandom));
      end
      cycle();
    end
  endtask

  initial begin
    logic [DW-1:0] old40;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = 32'hA5000000 + DW'(i * 32'h00010203);
      tb_mem[i]  = ref_mem[i];
    end
    owner = -1; turn = 0; burst = 0;
    exp_rv = '{1'b0, 1'b0};
    exp_rd = '{'0, '0};
    last_gnt = '{1'b0, 1'b0};
    last_dgnt = '{1'b0, 1'b0};

    // reset held with both ports requesting, then release into OWN0
    reset = 1'b0;
    set_port(0, 1'b1, 1'b0, 32'h4, '0);
    set_port(1, 1'b1, 1'b0, 32'hC, '0);
    repeat (3) cycle();
    reset = 1'b1;
    cycle();
    cycle();
    check("first_owner_gnt0", last_dgnt[0], 1);
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    repeat (3) cycle();

    // port 0 write then read-back of the same word
    issue(0, 1'b1, 32'h8, 32'hDEADBEEF);
    issue(0, 1'b0, 32'h8, '0);
    check("wr_rd_rvalid0", rvalid0, 1);
    check("wr_rd_rdata0", rdata0, 32'hDEADBEEF);
    set_port(0, 1'b0, 1'b0, '0, '0);
    repeat (2) cycle();

    // continuous contention: bursts of MB alternate with no gap
    random_phase(40, 100, 100);
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    repeat (3) cycle();

    // port 1 alone streams ten reads
    for (int i = 0; i < 10; i++) issue(1, 1'b0, AW'(i * 4), '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    repeat (3) cycle();

    // port 0 drops after two beats while port 1 waits
    issue(0, 1'b0, 32'h10, '0);
    set_port(1, 1'b1, 1'b0, 32'h20, '0);
    issue(0, 1'b0, 32'h14, '0);
    set_port(0, 1'b0, 1'b0, '0, '0);
    cycle();
    cycle();
    check("handoff_gnt1", last_dgnt[1], 1);
    set_port(1, 1'b0, 1'b0, '0, '0);
    cycle();
    set_port(0, 1'b1, 1'b0, 32'h30, '0);
    set_port(1, 1'b1, 1'b0, 32'h34, '0);
    cycle();
    cycle();
    check("rr_ptr_back_to_0", last_dgnt[0], 1);
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    repeat (3) cycle();

    random_phase(3000, 60, 60);
    random_phase(500, 90, 30);
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    repeat (3) cycle();

    // reset lands mid-burst on a port 1 write to 0x40
    issue(1, 1'b1, 32'h44, 32'h11112222);
    issue(1, 1'b1, 32'h48, 32'h33334444);
    old40 = ref_mem[16];
    set_port(1, 1'b1, 1'b1, 32'h40, 32'hCAFEF00D);
    reset = 1'b0;
    cycle();
    check("reset_blocks_write40", tb_mem[16], old40);
    check("reset_busy", busy, 0);
    check("reset_rvalid1", rvalid1, 0);
    reset = 1'b1;
    set_port(1, 1'b0, 1'b0, '0, '0);
    repeat (3) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
